// File: rtl/hamming_enc_pipe_if.sv
// hamming_enc_pipe_if: producer/consumer handshake, data and error-injection signals of the Hamming encoder
interface hamming_enc_pipe_if #(
    parameter int DW = 512,
    parameter int PW = 10,
    parameter int CW = 32
);
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [PW-1:0] o_parity;
    logic          i_inj_arm;
    logic [PW-1:0] i_inj_pos;
    logic          o_inj_pend;
    logic [CW-1:0] o_word_cnt;
    modport master (
        output i_valid, i_data, i_ready, i_inj_arm, i_inj_pos,
        input  o_ready, o_valid, o_data, o_parity, o_inj_pend, o_word_cnt
    );
    modport slave (
        input  i_valid, i_data, i_ready, i_inj_arm, i_inj_pos,
        output o_ready, o_valid, o_data, o_parity, o_inj_pend, o_word_cnt
    );
endinterface

// File: rtl/hamming_enc_pipe.sv
// hamming_enc_pipe: two-stage flow-controlled Hamming SEC encoder with one-shot single-bit error injection
module hamming_enc_pipe #(
    parameter int DW   = 512,
    parameter int PW   = 10,
    parameter int NSEG = 4,
    parameter int CW   = 32
) (
    input logic i_clk,
    input logic i_rst,
    hamming_enc_pipe_if.slave bus
);
    localparam int SEG = DW / NSEG;
    typedef logic [PW-1:0][DW-1:0] mask_t;
    // MASK[k][j] is bit k of the codeword position that holds data bit j
    function automatic mask_t gen_masks();
        mask_t m;
        int p;
        m = '0;
        p = 2;
        for (int j = 0; j < DW; j++) begin
            p++;
            while ((p & (p - 1)) == 0) p++;
            for (int k = 0; k < PW; k++) m[k][j] = 1'((p >> k) & 1);
        end
        return m;
    endfunction
    localparam mask_t MASK = gen_masks();
    logic                    in_fire, out_fire, s2_load, tag, pend, pos_pow, pos_data;
    logic [PW-1:0]           pos, s1_pos, par, pflip;
    logic                    s1_valid, s1_inj;
    logic [DW-1:0]           s1_data, dflip;
    logic [NSEG-1:0][PW-1:0] part, s1_part;
    int                      lg;
    assign s2_load        = !bus.o_valid || bus.i_ready;
    assign bus.o_ready    = !s1_valid || s2_load;
    assign in_fire        = bus.i_valid && bus.o_ready;
    assign out_fire       = bus.o_valid && bus.i_ready;
    // an arm coinciding with a handshake re-arms for the following word instead of tagging this one
    assign tag            = in_fire && pend && !bus.i_inj_arm;
    assign bus.o_inj_pend = pend;
    always_comb begin
        part = '0;
        for (int s = 0; s < NSEG; s++)
            for (int k = 0; k < PW; k++)
                part[s][k] = ^(bus.i_data[s*SEG +: SEG] & MASK[k][s*SEG +: SEG]);
    end
    always_comb begin
        par = '0;
        lg  = 0;
        for (int s = 0; s < NSEG; s++) par = par ^ s1_part[s];
        for (int k = 0; k < PW; k++) if (s1_pos[k]) lg = k;
        pos_pow  = (s1_pos != '0) && ((s1_pos & (s1_pos - PW'(1))) == '0);
        pos_data = (s1_pos != '0) && !pos_pow && (int'(s1_pos) <= DW + PW);
        pflip    = (s1_inj && pos_pow) ? s1_pos : '0;
        // data bit index = position minus the parity slots at or below it, minus one
        dflip    = (s1_inj && pos_data) ? DW'(1) << (int'(s1_pos) - lg - 2) : '0;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend <= 1'b0;
            pos  <= '0;
        end else if (bus.i_inj_arm) begin
            pend <= 1'b1;
            pos  <= bus.i_inj_pos;
        end else if (in_fire) begin
            pend <= 1'b0;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_part  <= '0;
            s1_inj   <= 1'b0;
            s1_pos   <= '0;
        end else if (bus.o_ready) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_data <= bus.i_data;
                s1_part <= part;
                s1_inj  <= tag;
                s1_pos  <= pos;
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_valid    <= 1'b0;
            bus.o_data     <= '0;
            bus.o_parity   <= '0;
            bus.o_word_cnt <= '0;
        end else begin
            if (s2_load) begin
                bus.o_valid <= s1_valid;
                if (s1_valid) begin
                    bus.o_data   <= s1_data ^ dflip;
                    bus.o_parity <= par ^ pflip;
                end
            end
            if (out_fire) bus.o_word_cnt <= bus.o_word_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_hamming_enc_pipe.sv
// tb_hamming_enc_pipe: randomized bench for hamming_enc_pipe against a position-table reference model and scoreboard
module tb_hamming_enc_pipe;
    localparam int DW = 512;
    localparam int PW = 10;
    localparam int NSEG = 4;
    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int pos_tab[DW];
    exp_t q[$];
    logic m_pend = 1'b0;
    logic [PW-1:0] m_pos = '0;
    int inflight = 0;
    logic stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic [PW-1:0] prev_p;
    hamming_enc_pipe_if #(.DW(DW), .PW(PW), .CW(32)) ifc ();
    hamming_enc_pipe_if #(.DW(DW), .PW(PW), .CW(4)) ifc4 ();
    hamming_enc_pipe #(.DW(DW), .PW(PW), .NSEG(NSEG), .CW(32)) dut (.i_clk(clk), .i_rst(rst), .bus(ifc));
    hamming_enc_pipe #(.DW(DW), .PW(PW), .NSEG(NSEG), .CW(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(ifc4));
    assign ifc4.i_valid   = ifc.i_valid;
    assign ifc4.i_data    = ifc.i_data;
    assign ifc4.i_ready   = ifc.i_ready;
    assign ifc4.i_inj_arm = ifc.i_inj_arm;
    assign ifc4.i_inj_pos = ifc.i_inj_pos;
    always #5 clk = ~clk;
    function automatic logic [PW-1:0] model_par(input logic [DW-1:0] d);
        int x = 0;
        for (int j = 0; j < DW; j++) if (d[j]) x = x ^ pos_tab[j];
        return PW'(x);
    endfunction
    function automatic logic [PW-1:0] syndrome(input logic [DW-1:0] d, input logic [PW-1:0] p);
        return model_par(d) ^ p;
    endfunction
    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    // scoreboard, stall stability, ready rule and injection-arm model, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_pend = 1'b0;
            inflight = 0;
            stall = 1'b0;
        end else begin
            logic in_f, out_f, tg;
            exp_t e, g;
            in_f = ifc.i_valid && ifc.o_ready;
            out_f = ifc.o_valid && ifc.i_ready;
            checks++;
            if (ifc.o_ready !== !(inflight == 2 && !ifc.i_ready)) begin
                failures++;
                $display("FAIL ready_rule got=%b inflight=%0d i_ready=%b", ifc.o_ready, inflight, ifc.i_ready);
            end
            checks++;
            if (ifc.o_inj_pend !== m_pend) begin
                failures++;
                $display("FAIL inj_pend got=%b exp=%b", ifc.o_inj_pend, m_pend);
            end
            if (stall) begin
                checks++;
                if (ifc.o_valid !== 1'b1 || ifc.o_data !== prev_d || ifc.o_parity !== prev_p) begin
                    failures++;
                    $display("FAIL stall_stable got v=%b p=%h exp v=1 p=%h", ifc.o_valid, ifc.o_parity, prev_p);
                end
            end
            if (out_f) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard got=unexpected_word exp=empty");
                end else begin
                    e = q.pop_front();
                    if (ifc.o_data !== e.d || ifc.o_parity !== e.p) begin
                        failures++;
                        $display("FAIL scoreboard got p=%h d=%h exp p=%h d=%h", ifc.o_parity, ifc.o_data, e.p, e.d);
                    end
                end
            end
            tg = in_f && m_pend && !ifc.i_inj_arm;
            if (in_f) begin
                g.d = ifc.i_data;
                g.p = model_par(ifc.i_data);
                if (tg) begin
                    for (int j = 0; j < DW; j++) if (pos_tab[j] == int'(m_pos)) g.d[j] = ~g.d[j];
                    for (int k = 0; k < PW; k++) if (int'(m_pos) == (1 << k)) g.p[k] = ~g.p[k];
                end
                q.push_back(g);
            end
            if (ifc.i_inj_arm) begin
                m_pend = 1'b1;
                m_pos = ifc.i_inj_pos;
            end else if (in_f) m_pend = 1'b0;
            inflight = inflight + int'(in_f) - int'(out_f);
            stall = ifc.o_valid && !ifc.i_ready;
            prev_d = ifc.o_data;
            prev_p = ifc.o_parity;
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic reset_dut();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask
    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        ifc.i_valid = 1'b1;
        ifc.i_data = d;
        while (!ifc.o_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=o_ready_low exp=o_ready_high");
        end
        step();
        ifc.i_valid = 1'b0;
    endtask
    task automatic wait_out(output logic [DW-1:0] d, output logic [PW-1:0] p);
        int n = 0;
        while (!ifc.o_valid && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL out_timeout got=o_valid_low exp=o_valid_high");
        end
        d = ifc.o_data;
        p = ifc.o_parity;
        step();
    endtask
    task automatic test_reset();
        step();
        checks++;
        if (ifc.o_valid !== 1'b0 || ifc.o_data !== '0 || ifc.o_parity !== '0 || ifc.o_inj_pend !== 1'b0
            || ifc.o_word_cnt !== '0 || ifc.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got v=%b p=%h pend=%b cnt=%0d rdy=%b exp v=0 p=0 pend=0 cnt=0 rdy=1",
                     ifc.o_valid, ifc.o_parity, ifc.o_inj_pend, ifc.o_word_cnt, ifc.o_ready);
        end
        rst = 1'b0;
    endtask
    task automatic test_basic();
        logic [DW-1:0] vec[5];
        logic [PW-1:0] ep[5];
        vec[0] = '0; vec[1] = DW'(1); vec[2] = DW'(2); vec[3] = DW'(3); vec[4] = '1;
        ep[0] = 10'h000; ep[1] = 10'h003; ep[2] = 10'h005; ep[3] = 10'h006; ep[4] = model_par(vec[4]);
        ifc.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifc.i_valid = 1'b1;
            ifc.i_data = vec[i];
            step();
            ifc.i_valid = 1'b0;
            checks++;
            if (ifc.o_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_early[%0d] got=%b exp=0", i, ifc.o_valid);
            end
            step();
            checks++;
            if (ifc.o_valid !== 1'b1 || ifc.o_parity !== ep[i] || ifc.o_data !== vec[i]) begin
                failures++;
                $display("FAIL basic_parity[%0d] got v=%b p=%h exp v=1 p=%h", i, ifc.o_valid, ifc.o_parity, ep[i]);
            end
            step();
        end
    endtask
    task automatic test_back_to_back();
        int gaps = 0;
        reset_dut();
        ifc.i_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ifc.i_valid = 1'b1;
            ifc.i_data = rnd();
            step();
            if (i >= 1 && !ifc.o_valid) gaps++;
        end
        ifc.i_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL stream_gaps got=%0d exp=0", gaps);
        end
        checks++;
        if (ifc.o_word_cnt !== 32'd1000 || q.size() != 0) begin
            failures++;
            $display("FAIL stream_count got=%0d left=%0d exp=1000 left=0", ifc.o_word_cnt, q.size());
        end
    endtask
    task automatic test_backpressure();
        for (int i = 0; i < 600; i++) begin
            ifc.i_valid = 1'($urandom_range(0, 1));
            ifc.i_data = rnd();
            ifc.i_ready = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            step();
        end
        ifc.i_valid = 1'b0;
        ifc.i_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain got=%0d exp=0", q.size());
        end
    endtask
    task automatic inj_case(input logic [PW-1:0] pos, input logic [PW-1:0] esyn);
        logic [DW-1:0] d, od, cd;
        logic [PW-1:0] op, syn;
        d = rnd();
        ifc.i_ready = 1'b1;
        ifc.i_inj_arm = 1'b1;
        ifc.i_inj_pos = pos;
        step();
        ifc.i_inj_arm = 1'b0;
        checks++;
        if (ifc.o_inj_pend !== 1'b1) begin
            failures++;
            $display("FAIL inj_arm_pend[%0d] got=%b exp=1", pos, ifc.o_inj_pend);
        end
        send(d);
        checks++;
        if (ifc.o_inj_pend !== 1'b0) begin
            failures++;
            $display("FAIL inj_consume[%0d] got=%b exp=0", pos, ifc.o_inj_pend);
        end
        wait_out(od, op);
        syn = syndrome(od, op);
        cd = od;
        for (int j = 0; j < DW; j++) if (pos_tab[j] == int'(syn)) cd[j] = ~cd[j];
        checks++;
        if (syn !== esyn || cd !== d) begin
            failures++;
            $display("FAIL inj_syndrome[%0d] got=%0d corrected_ok=%b exp=%0d corrected_ok=1", pos, syn, cd === d, esyn);
        end
    endtask
    task automatic test_inject();
        logic [DW-1:0] d1, d2, o1, o2;
        logic [PW-1:0] p1, p2;
        inj_case(10'd3, 10'd3);
        inj_case(10'd8, 10'd8);
        inj_case(10'd0, 10'd0);
        inj_case(10'd600, 10'd0);
        inj_case(10'd522, 10'd522);
        d1 = rnd();
        d2 = rnd();
        ifc.i_inj_arm = 1'b1;
        ifc.i_inj_pos = 10'd5;
        ifc.i_valid = 1'b1;
        ifc.i_data = d1;
        step();
        ifc.i_inj_arm = 1'b0;
        ifc.i_data = d2;
        step();
        ifc.i_valid = 1'b0;
        wait_out(o1, p1);
        wait_out(o2, p2);
        checks++;
        if (syndrome(o1, p1) !== 10'd0 || o1 !== d1) begin
            failures++;
            $display("FAIL inj_coincident_first got=%0d exp=0", syndrome(o1, p1));
        end
        checks++;
        if (syndrome(o2, p2) !== 10'd5 || (o2 ^ d2) !== DW'(2)) begin
            failures++;
            $display("FAIL inj_coincident_next got=%0d exp=5", syndrome(o2, p2));
        end
    endtask
    task automatic test_reset_flight();
        logic [DW-1:0] d3, od;
        logic [PW-1:0] op;
        ifc.i_ready = 1'b0;
        send(rnd());
        send(rnd());
        ifc.i_inj_arm = 1'b1;
        ifc.i_inj_pos = 10'd3;
        step();
        ifc.i_inj_arm = 1'b0;
        checks++;
        if (ifc.o_ready !== 1'b0 || ifc.o_inj_pend !== 1'b1 || ifc.o_valid !== 1'b1) begin
            failures++;
            $display("FAIL flight_setup got rdy=%b pend=%b v=%b exp rdy=0 pend=1 v=1", ifc.o_ready, ifc.o_inj_pend, ifc.o_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.o_valid !== 1'b0 || ifc.o_data !== '0 || ifc.o_parity !== '0 || ifc.o_inj_pend !== 1'b0
            || ifc.o_word_cnt !== '0 || ifc.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got v=%b p=%h pend=%b cnt=%0d rdy=%b exp v=0 p=0 pend=0 cnt=0 rdy=1",
                     ifc.o_valid, ifc.o_parity, ifc.o_inj_pend, ifc.o_word_cnt, ifc.o_ready);
        end
        step();
        rst = 1'b0;
        ifc.i_ready = 1'b1;
        d3 = rnd();
        send(d3);
        wait_out(od, op);
        checks++;
        if (od !== d3 || syndrome(od, op) !== 10'd0) begin
            failures++;
            $display("FAIL post_reset_clean got=%0d exp=0", syndrome(od, op));
        end
    endtask
    task automatic test_counter_wrap();
        reset_dut();
        ifc.i_ready = 1'b1;
        ifc.i_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ifc.i_data = rnd();
            step();
        end
        ifc.i_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (ifc4.o_word_cnt !== 4'd1 || ifc.o_word_cnt !== 32'd17) begin
            failures++;
            $display("FAIL counter_wrap got=%0d/%0d exp=1/17", ifc4.o_word_cnt, ifc.o_word_cnt);
        end
    endtask
    initial begin
        int p = 2;
        for (int j = 0; j < DW; j++) begin
            p++;
            while ((p & (p - 1)) == 0) p++;
            pos_tab[j] = p;
        end
        ifc.i_valid = 1'b0;
        ifc.i_data = '0;
        ifc.i_ready = 1'b1;
        ifc.i_inj_arm = 1'b0;
        ifc.i_inj_pos = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_inject();
        test_reset_flight();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
